// File: rtl/detector_stream_sched_pkg.sv
// Shared definitions for the detector stream scheduler: state encodings,
// the requester vector type, default sizes and a one-hot helper.
package detector_stream_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SHIFT  = 3'd1;
  localparam state_t ST_GAP    = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_REPORT = 3'd4;

  typedef logic [1:0] req_t;

  function automatic req_t oneHot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester preferred
// next; after a grant it moves to the other requester, so two persistent
// requesters alternate and neither starves.
module rr_arb2
  import detector_stream_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  req_t i_req,
  input  logic i_advance,
  output req_t o_grant
);

  logic r_ptr;
  logic w_pick;

  // Prefer the pointed-to requester, fall back to the other one
  always_comb begin
    w_pick = r_ptr;
    if (!i_req[r_ptr]) w_pick = ~r_ptr;
    o_grant = i_req[w_pick] ? oneHot2(w_pick) : 2'b00;
  end

  // Move priority past the requester that was just served
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (|o_grant)) begin
      r_ptr <= ~w_pick;
    end
  end

endmodule

// File: rtl/detector_stream_sched.sv
// Shares one serial sequence detector between two requesters. A granted
// word is shifted MSB-first onto x; z pulses inside the word's hit window
// are counted (saturating) and returned with a done pulse.
// Build option: FLUSH_GAP_EN inserts GAP zero bits after each word so the
// detector history does not leak into the next word.
module detector_stream_sched
  import detector_stream_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DET_LAT = 1,
  parameter int CW      = DEF_CW,
  parameter int GAP     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic [1:0]       done,
  output logic [CW-1:0]    hits,
  output logic             owner,
  output logic             busy,
  output logic             x,
  input  logic             z
);

`ifdef FLUSH_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int GAP_CYC = GAP_EN ? GAP : 0;
  localparam int CNTW    = $clog2(WIDTH + GAP_CYC + DET_LAT + 2);

  // Cycle offsets measured from the ack cycle (offset 0)
  localparam logic [CNTW-1:0] LAST_SHIFT = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] LAST_DRAIN = CNTW'(WIDTH + GAP_CYC + DET_LAT - 1);
  localparam logic [CNTW-1:0] WIN_LO     = CNTW'(1 + DET_LAT);
  localparam logic [CNTW-1:0] WIN_HI     = CNTW'(WIDTH + DET_LAT);
`ifdef FLUSH_GAP_EN
  localparam logic [CNTW-1:0] LAST_GAP   = CNTW'(WIDTH + GAP_CYC - 1);
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNTW-1:0]  r_cnt;
  logic [CW-1:0]    r_hitCnt;
  logic [CW-1:0]    r_hits;
  logic [1:0]       r_ack;
  logic [1:0]       r_done;
  logic             r_owner;
  logic             r_busy;
  logic             r_x;

  req_t             w_grant;
  logic             w_sample;
  logic [CW-1:0]    w_hitInc;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_advance (r_state == ST_IDLE),
    .o_grant   (w_grant)
  );

  // A z pulse counts only inside the word's window; counter saturates
  always_comb begin
    w_sample = (r_state != ST_IDLE) && z && (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
    w_hitInc = (&r_hitCnt) ? r_hitCnt : r_hitCnt + CW'(1);
  end

  // Grant, serialize, flush, drain and report one word at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_hitCnt <= '0;
      r_hits   <= '0;
      r_ack    <= 2'b00;
      r_done   <= 2'b00;
      r_owner  <= 1'b1;
      r_busy   <= 1'b0;
      r_x      <= 1'b0;
    end else begin
      r_ack  <= 2'b00;
      r_done <= 2'b00;
      if (r_state != ST_IDLE) r_cnt <= r_cnt + CNTW'(1);
      if (w_sample) r_hitCnt <= w_hitInc;
      case (r_state)
        ST_IDLE: begin
          r_x <= 1'b0;
          if (|w_grant) begin
            r_ack    <= w_grant;
            r_shreg  <= w_grant[1] ? data1 : data0;
            r_owner  <= w_grant[1];
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_hitCnt <= '0;
            r_state  <= ST_SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_x     <= r_shreg[WIDTH-1];
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          if (r_cnt == LAST_SHIFT) begin
`ifdef FLUSH_GAP_EN
            r_state <= ST_GAP;
`else
            r_state <= (DET_LAT > 0) ? ST_DRAIN : ST_REPORT;
`endif
          end
        end
`ifdef FLUSH_GAP_EN
        ST_GAP: begin
          r_x <= 1'b0;
          if (r_cnt == LAST_GAP) r_state <= (DET_LAT > 0) ? ST_DRAIN : ST_REPORT;
        end
`endif
        ST_DRAIN: begin
          r_x <= 1'b0;
          if (r_cnt == LAST_DRAIN) r_state <= ST_REPORT;
        end
        ST_REPORT: begin
          r_x     <= 1'b0;
          r_done  <= oneHot2(r_owner);
          r_hits  <= w_sample ? w_hitInc : r_hitCnt;
          r_state <= ST_IDLE;
        end
        default: begin
          r_x     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign done  = r_done;
  assign hits  = r_hits;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign x     = r_x;

endmodule

// File: tb/tb_detector_stream_sched.sv
// Scoreboard bench for detector_stream_sched. Stimulus pushes the expected
// job (requester, word, z pattern, hit count) into a queue; a monitor pops
// it on ack, drives z over the job, checks x/busy each cycle and checks
// done/hits/latency. A second instance with CW=2 and z stuck high checks
// counter saturation on every job.
module tb_detector_stream_sched;

  localparam int W  = 8;
  localparam int DL = 1;
  localparam int CW = 4;
`ifdef FLUSH_GAP_EN
  localparam int GAPC = 3;
`else
  localparam int GAPC = 0;
`endif
  localparam int ENDOFF = W + GAPC + DL;

  typedef struct {
    logic          idx;
    logic [W-1:0]  word;
    logic [W-1:0]  mask;
    logic          pre;
    logic          post;
    logic [CW-1:0] hits;
  } job_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         z = 1'b0;
  logic         zSat = 1'b1;
  logic [1:0]   ack, done, satAck, satDone;
  logic [CW-1:0] hits;
  logic [1:0]   satHits;
  logic         owner, busy, x, satOwner, satBusy, satX;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tAck = 0;
  bit   active = 0;
  job_t cur;
  job_t expQ[$];
  job_t doneQ[$];

  detector_stream_sched #(.WIDTH(W), .DET_LAT(DL), .CW(CW), .GAP(3)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .done(done), .hits(hits), .owner(owner), .busy(busy),
    .x(x), .z(z)
  );

  detector_stream_sched #(.WIDTH(W), .DET_LAT(DL), .CW(2), .GAP(3)) u_dutSat (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .ack(satAck), .done(satDone), .hits(satHits), .owner(satOwner), .busy(satBusy),
    .x(satX), .z(zSat)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [CW-1:0] expHits(input logic [W-1:0] m);
    int n = 0;
    for (int k = 0; k < W; k++) n += int'(m[k]);
    if (n > (2**CW) - 1) n = (2**CW) - 1;
    return CW'(n);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=timeout/unexpected want=expected event (cycle %0d)", name, cyc);
  endtask

  task automatic pushJob(input logic idx, input logic [W-1:0] word, input logic [W-1:0] mask,
                         input logic pre, input logic post);
    job_t j;
    j.idx = idx; j.word = word; j.mask = mask; j.pre = pre; j.post = post;
    j.hits = expHits(mask);
    expQ.push_back(j);
  endtask

  task automatic waitAck(output logic g, output bit ok);
    ok = 0;
    g = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        g = ack[1];
        ok = 1;
        break;
      end
    end
    if (!ok) failNow("ackTimeout");
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || doneQ.size() != 0 || active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) failNow("idleTimeout");
    @(negedge clk);
    checkOutput("busyIdle", busy, 0);
  endtask

  task automatic applyStimulus(input logic idx, input logic [W-1:0] word, input logic [W-1:0] mask,
                               input logic pre, input logic post);
    logic g;
    bit ok;
    pushJob(idx, word, mask, pre, post);
    if (idx) data1 = word; else data0 = word;
    req[idx] = 1'b1;
    waitAck(g, ok);
    req[idx] = 1'b0;
    if (idx) data1 = ~word; else data0 = ~word;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    doneQ.delete();
    active = 0;
    z = 1'b0;
  endtask

  // Monitor: pop on ack, drive z over the job, check x/busy, check done
  initial begin
    int off;
    logic expX;
    job_t j;
    forever begin
      @(negedge clk);
      cyc++;
      if (ack != 2'b00) begin
        if (expQ.size() == 0) begin
          failNow("unexpectedAck");
        end else begin
          cur = expQ.pop_front();
          checkOutput("ackWho", ack, oh(cur.idx));
          checkOutput("ownerAtAck", owner, cur.idx);
          checkOutput("satAck", satAck, oh(cur.idx));
          tAck = cyc;
          active = 1;
          doneQ.push_back(cur);
        end
      end
      off = cyc - tAck;
      z = 1'b0;
      if (active) begin
        if (off == DL) z = cur.pre;
        else if (off >= DL + 1 && off <= W + DL) z = cur.mask[off-1-DL];
        else if (off == W + DL + 1) z = cur.post;
        expX = (off >= 1 && off <= W) ? cur.word[W-off] : 1'b0;
        checkOutput("xBit", x, expX);
        checkOutput("satX", satX, expX);
        checkOutput("busyJob", busy, 1);
        if (off > ENDOFF + 1) begin
          failNow("doneMissing");
          active = 0;
          if (doneQ.size() != 0) void'(doneQ.pop_front());
        end
      end
      if (done != 2'b00) begin
        if (doneQ.size() == 0) begin
          failNow("unexpectedDone");
        end else begin
          j = doneQ.pop_front();
          checkOutput("doneWho", done, oh(j.idx));
          checkOutput("hits", hits, j.hits);
          checkOutput("latency", off, ENDOFF + 1);
          checkOutput("satDone", satDone, oh(j.idx));
          checkOutput("satHits", satHits, 3);
          active = 0;
        end
      end else if (satDone != 2'b00) begin
        failNow("satDoneAlone");
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    logic g;
    bit ok;
    int cnt0, cnt1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstX", x, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstHits", hits, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOwner", owner, 1);
    rst = 1'b0;

    $display("[TB] contention: req=11 for four words");
    pushJob(1'b0, 8'hA5, 8'h01, 1'b0, 1'b0);
    pushJob(1'b1, 8'h3C, 8'h81, 1'b0, 1'b0);
    pushJob(1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0);
    pushJob(1'b1, 8'hE1, 8'h7F, 1'b0, 1'b0);
    data0 = 8'hA5;
    data1 = 8'h3C;
    @(negedge clk);
    req = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int n = 0; n < 4; n++) begin
      waitAck(g, ok);
      if (!ok) break;
      if (!g) begin
        if (cnt0 == 0) data0 = 8'h0F; else begin req[0] = 1'b0; data0 = 8'h00; end
        cnt0++;
      end else begin
        if (cnt1 == 0) data1 = 8'hE1; else begin req[1] = 1'b0; data1 = 8'h00; end
        cnt1++;
      end
    end
    req = 2'b00;
    waitIdle();

    $display("[TB] single word 0xB2, z on bits 3 and 6");
    applyStimulus(1'b0, 8'hB2, 8'h48, 1'b0, 1'b0);
    waitIdle();

    $display("[TB] window edges: z just outside the window");
    applyStimulus(1'b1, 8'h6D, 8'hFF, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 8'h92, 8'h00, 1'b1, 1'b1);
    waitIdle();

    $display("[TB] reset during shift");
    pushJob(1'b0, 8'h55, 8'hFF, 1'b0, 1'b0);
    data0 = 8'h55;
    req[0] = 1'b1;
    waitAck(g, ok);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    doReset(1);
    checkOutput("midRstX", x, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstOwner", owner, 1);
    repeat (20) @(negedge clk);
    checkOutput("midRstIdleBusy", busy, 0);

    $display("[TB] re-request after reset");
    applyStimulus(1'b0, 8'h55, 8'h10, 1'b0, 1'b0);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detector_stream_sched.md
Name: detector_stream_sched

Overview:
- Round-robin scheduler that shares one serial sequence-detector instance between two requesters.
- Detector interface: serial input x, output flag z.
- Each requester hands over a WIDTH-bit word. The block serializes it MSB-first onto x, one bit per clk, and counts z assertions attributable to that word.
- The hit count is returned to the owning requester with a done pulse.
- Sits between the detector and its upstream producers.

Parameters:
- WIDTH, 8, bits per word shifted into the detector (2..32).
- DET_LAT, 1, cycles from x driven to corresponding z valid (0..3).
- CW, 4, hit-counter width; must hold WIDTH, saturates at 2^CW-1.
- GAP, 3, flush bits driven between words when FLUSH_GAP_EN is defined (1..8).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  2  request, one bit per requester; level, held until ack
- data0  input  WIDTH  word of requester 0, sampled at ack
- data1  input  WIDTH  word of requester 1, sampled at ack
- ack  output  2  one-cycle pulse: word accepted
- done  output  2  one-cycle pulse: hits valid for that requester
- hits  output  CW  hit count, valid while done!=0, held otherwise
- owner  output  1  index of current/last granted requester
- busy  output  1  high from grant until done cycle inclusive
- x  output  1  serial bit to detector
- z  input  1  detector match flag

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, x=0, ack=0, done=0, hits=0, busy=0, owner=1.
  - Priority pointer points to requester 0 first.
  - Reset mid-word aborts it: no done is issued and the requester must re-request.
- States and transitions:
  - IDLE: if any req is set, grant per round-robin. Pointer = requester after last owner; if only one requests, it wins. Same cycle: ack[g]=1, shift register<=data_g, owner<=g, busy=1, bit counter=0, hit counter=0 -> SHIFT.
  - SHIFT: x=shreg[WIDTH-1], shift left each cycle. First bit appears on x the cycle after ack. Exactly WIDTH cycles -> DRAIN, or -> GAP with FLUSH_GAP_EN.
  - DRAIN: x=0 for DET_LAT cycles, then -> REPORT. With DET_LAT=0, DRAIN is skipped.
  - REPORT: one cycle: done[owner]=1, hits=final count, busy=0 the following cycle -> IDLE.
- Hit window:
  - z is sampled in the WIDTH consecutive cycles beginning DET_LAT cycles after the first bit is on x.
  - Each sampled z=1 increments the counter, saturating.
  - z outside the window is ignored.
- Back-to-back: the earliest next ack is the cycle after REPORT (IDLE lasts at least one cycle). Per-word turnaround is 1+WIDTH+DET_LAT+1 cycles.
- Simultaneous req=2'b11: alternates grants 0,1,0,1; neither requester starves.
- req dropped before ack: no grant is issued. req dropped after ack: no effect.
- A data change after ack has no effect on the word in flight.
- x is registered. ack and done are registered, and never both high for the same requester in one cycle.

Optional Feature:
- Macro FLUSH_GAP_EN.
- Defined:
  - After SHIFT, GAP state drives x=0 for GAP cycles to clear detector history, then -> DRAIN.
  - z is still ignored outside the hit window.
  - Turnaround grows by GAP.
- Undefined:
  - No GAP state.
  - Detector history carries over between consecutive words; cross-word matches falling inside the next window are counted.

Decomposition:
- Shared package holds:
  - state enum: IDLE, SHIFT, GAP, DRAIN, REPORT
  - 2-bit requester type
  - default WIDTH/CW constants
- One natural sub-module: rr_arb2, a two-way round-robin arbiter (req, advance, grant one-hot, pointer).
- Shift/count logic stays in the top.

Test Plan:
- Single word: rst 2 cycles; req=01, data0=8'b1011_0010, bench model asserts z on bits 3 and 6 -> ack[0] next cycle; x sequence 1,0,1,1,0,0,1,0; done[0] with hits=2 at cycle ack+WIDTH+DET_LAT+1.
- Contention: req=11 held for 4 words -> grants in order 0,1,0,1; owner toggles; each done matches its own data.
- Window edge: z=1 the cycle before the window and the cycle after it, plus z held high through the whole window -> hits=8 (only in-window samples counted).
- Saturation: CW=2, z stuck high -> hits=3.
- Reset mid-SHIFT: rst at bit 4 -> next cycle x=0, busy=0, no done; re-request completes normally.
- FLUSH_GAP_EN build: two back-to-back words -> x=0 for exactly GAP cycles between the last bit and the DRAIN/REPORT sequence; turnaround = 2+WIDTH+DET_LAT+GAP.
